reg_wb_arbiter: RTL and testbench

Write-back arbiter and scoreboard for the 32-entry register file. It shares the file's single write port (A3/WD/We) between two requesters: requester 0 is ALU/execute write-back and requester 1 is load-return write-back. Arbitration is round-robin with valid/ready handshakes, followed by one registered output stage. An optional pending-destination scoreboard tells the issue stage when rs1/rs2 still await a write.

---
 rtl/reg_wb_arbiter.sv | 101 ++++++++++
 tb/tb_reg_wb_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/reg_wb_arbiter.sv
// Round-robin write-back arbiter for the register file's single write port, with an optional
// pending-destination scoreboard. Define WB_SCOREBOARD_EN to build the scoreboard.
module reg_wb_arbiter #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [AW-1:0]   req0_rd,
  input  logic [XLEN-1:0] req0_data,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [AW-1:0]   req1_rd,
  input  logic [XLEN-1:0] req1_data,
  output logic [AW-1:0]   A3,
  output logic [XLEN-1:0] WD,
  output logic            We,
  input  logic            alloc_valid,
  input  logic [AW-1:0]   alloc_rd,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic            busy_rs1,
  output logic            busy_rs2
);

  logic            last_grant;
  logic            xfer;
  logic [AW-1:0]   win_rd;
  logic [XLEN-1:0] win_data;

  // last_grant == 1 means requester 1 won most recently, so requester 0 wins a tie.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (rst) begin
      if (req0_valid && req1_valid) begin
        req0_ready = last_grant;
        req1_ready = ~last_grant;
      end else begin
        req0_ready = req0_valid;
        req1_ready = req1_valid;
      end
    end
  end

  assign xfer     = req0_ready | req1_ready;
  assign win_rd   = req1_ready ? req1_rd   : req0_rd;
  assign win_data = req1_ready ? req1_data : req0_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      A3         <= '0;
      WD         <= '0;
      We         <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      We <= 1'b0;
      if (xfer) begin
        A3         <= win_rd;
        WD         <= win_data;
        We         <= (win_rd != '0);
        last_grant <= req1_ready;
      end
    end
  end

`ifdef WB_SCOREBOARD_EN
  localparam int NREG = 1 << AW;

  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_nxt;

  // A new allocation overrides a retiring write to the same register: the new producer is still outstanding.
  always_comb begin
    pending_nxt = pending;
    if (We)
      pending_nxt[A3] = 1'b0;
    if (alloc_valid && (alloc_rd != '0))
      pending_nxt[alloc_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      pending <= '0;
    else
      pending <= pending_nxt;
  end

  assign busy_rs1 = pending[rs1];
  assign busy_rs2 = pending[rs2];
`else
  logic unused_sb;
  assign unused_sb = ^{alloc_valid, alloc_rd, rs1, rs2};
  assign busy_rs1  = 1'b0;
  assign busy_rs2  = 1'b0;
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter: vector table for arbitration and output stage,
// hand sequences for reset, scoreboard and set/clear collision.
module tb_reg_wb_arbiter;

`ifdef WB_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [4:0]  req0_rd, req1_rd;
  logic [31:0] req0_data, req1_data;
  logic [4:0]  A3;
  logic [31:0] WD;
  logic        We;
  logic        alloc_valid;
  logic [4:0]  alloc_rd, rs1, rs2;
  logic        busy_rs1, busy_rs2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_wb_arbiter #(.XLEN(32), .AW(5)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rd(req0_rd), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rd(req1_rd), .req1_data(req1_data),
    .A3(A3), .WD(WD), .We(We),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
    .rs1(rs1), .rs2(rs2), .busy_rs1(busy_rs1), .busy_rs2(busy_rs2)
  );

  typedef struct {
    logic        v0;
    logic [4:0]  rd0;
    logic [31:0] d0;
    logic        v1;
    logic [4:0]  rd1;
    logic [31:0] d1;
    logic        e_r0;
    logic        e_r1;
    logic        e_we;
    logic [4:0]  e_a3;
    logic [31:0] e_wd;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Grant pointer starts at 1 after reset, so a tie goes to req0 first.
    vecs[0]  = '{1, 5'd3, 32'h11, 1, 5'd4, 32'h22, 1, 0, 1, 5'd3, 32'h11};
    vecs[1]  = '{1, 5'd3, 32'h11, 1, 5'd4, 32'h22, 0, 1, 1, 5'd4, 32'h22};
    vecs[2]  = '{1, 5'd3, 32'h11, 1, 5'd4, 32'h22, 1, 0, 1, 5'd3, 32'h11};
    vecs[3]  = '{1, 5'd3, 32'h11, 1, 5'd4, 32'h22, 0, 1, 1, 5'd4, 32'h22};
    vecs[4]  = '{0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  0, 0, 0, 5'd4, 32'h22};
    vecs[5]  = '{0, 5'd0, 32'h0,  1, 5'd7, 32'hDEADBEEF, 0, 1, 1, 5'd7, 32'hDEADBEEF};
    vecs[6]  = '{0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  0, 0, 0, 5'd7, 32'hDEADBEEF};
    vecs[7]  = '{1, 5'd0, 32'hFFFFFFFF, 0, 5'd0, 32'h0, 1, 0, 0, 5'd0, 32'hFFFFFFFF};
    vecs[8]  = '{1, 5'd2, 32'h5,  0, 5'd0, 32'h0,  1, 0, 1, 5'd2, 32'h5};
    vecs[9]  = '{1, 5'd1, 32'h1,  1, 5'd6, 32'h66, 0, 1, 1, 5'd6, 32'h66};
    vecs[10] = '{1, 5'd1, 32'h1,  1, 5'd6, 32'h66, 1, 0, 1, 5'd1, 32'h1};
    vecs[11] = '{0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  0, 0, 0, 5'd1, 32'h1};

    rst = 1'b0;
    req0_valid = 0; req1_valid = 0;
    req0_rd = 0; req1_rd = 0; req0_data = 0; req1_data = 0;
    alloc_valid = 0; alloc_rd = 0; rs1 = 0; rs2 = 0;

    step();
    chk("por_we", {31'b0, We}, 32'd0);
    chk("por_a3", {27'b0, A3}, 32'd0);
    chk("por_wd", WD, 32'd0);
    #3 rst = 1'b1;
    step();

    // Mid-stream reset: output stage holds a write, a destination is pending, grant pointer is 0.
    req0_valid = 1; req0_rd = 5'd3; req0_data = 32'h11;
    req1_valid = 1; req1_rd = 5'd4; req1_data = 32'h22;
    alloc_valid = 1; alloc_rd = 5'd12;
    #1;
    chk("pre_rst_rdy0", {31'b0, req0_ready}, 32'd1);
    step();
    alloc_valid = 0; rs1 = 5'd12;
    #1;
    chk("pre_rst_we", {31'b0, We}, 32'd1);
    chk("pre_rst_busy", {31'b0, busy_rs1}, {31'b0, SB});
    rst = 1'b0;
    #1;
    chk("rst_we", {31'b0, We}, 32'd0);
    chk("rst_a3", {27'b0, A3}, 32'd0);
    chk("rst_wd", WD, 32'd0);
    chk("rst_busy", {31'b0, busy_rs1}, 32'd0);
    chk("rst_rdy0", {31'b0, req0_ready}, 32'd0);
    chk("rst_rdy1", {31'b0, req1_ready}, 32'd0);
    step();
    chk("rst_hold_we", {31'b0, We}, 32'd0);
    chk("rst_hold_rdy", {30'b0, req0_ready, req1_ready}, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 12; i++) begin
      req0_valid = vecs[i].v0; req0_rd = vecs[i].rd0; req0_data = vecs[i].d0;
      req1_valid = vecs[i].v1; req1_rd = vecs[i].rd1; req1_data = vecs[i].d1;
      #1;
      chk($sformatf("v%0d_rdy0", i), {31'b0, req0_ready}, {31'b0, vecs[i].e_r0});
      chk($sformatf("v%0d_rdy1", i), {31'b0, req1_ready}, {31'b0, vecs[i].e_r1});
      step();
      chk($sformatf("v%0d_we", i), {31'b0, We}, {31'b0, vecs[i].e_we});
      chk($sformatf("v%0d_a3", i), {27'b0, A3}, {27'b0, vecs[i].e_a3});
      chk($sformatf("v%0d_wd", i), WD, vecs[i].e_wd);
    end
    req0_valid = 0; req1_valid = 0;

    // Scoreboard: alloc, then the write clears busy on the register-file write edge.
    alloc_valid = 1; alloc_rd = 5'd5; rs1 = 5'd5; rs2 = 5'd0;
    #1;
    chk("sb_busy_before", {31'b0, busy_rs1}, 32'd0);
    step();
    alloc_valid = 0;
    #1;
    chk("sb_busy_set", {31'b0, busy_rs1}, {31'b0, SB});
    chk("sb_busy_x0", {31'b0, busy_rs2}, 32'd0);
    req0_valid = 1; req0_rd = 5'd5; req0_data = 32'h55;
    #1;
    chk("sb_rdy0", {31'b0, req0_ready}, 32'd1);
    step();
    req0_valid = 0;
    chk("sb_we", {31'b0, We}, 32'd1);
    chk("sb_a3", {27'b0, A3}, 32'd5);
    chk("sb_busy_wait", {31'b0, busy_rs1}, {31'b0, SB});
    step();
    chk("sb_we_off", {31'b0, We}, 32'd0);
    chk("sb_busy_clr", {31'b0, busy_rs1}, 32'd0);

    // Collision: write of r9 retires on the same edge a new alloc of r9 arrives.
    alloc_valid = 1; alloc_rd = 5'd9; rs1 = 5'd9; rs2 = 5'd5;
    step();
    alloc_valid = 0;
    req0_valid = 1; req0_rd = 5'd9; req0_data = 32'h99;
    step();
    req0_valid = 0;
    chk("col_we", {31'b0, We}, 32'd1);
    chk("col_a3", {27'b0, A3}, 32'd9);
    alloc_valid = 1; alloc_rd = 5'd9;
    step();
    alloc_valid = 0;
    chk("col_busy", {31'b0, busy_rs1}, {31'b0, SB});
    chk("col_other", {31'b0, busy_rs2}, 32'd0);
    step();
    chk("col_busy_hold", {31'b0, busy_rs1}, {31'b0, SB});

    // Alloc of x0 never marks anything pending.
    alloc_valid = 1; alloc_rd = 5'd0; rs2 = 5'd0;
    step();
    alloc_valid = 0;
    chk("x0_alloc", {31'b0, busy_rs2}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
